// File: rtl/dac_update_sequencer.sv
// Shares the threshold-DAC serializer between software words and the shadow-config
// channel sequencer, and supervises the start/busy handshake with a timeout.
module dac_update_sequencer #(
  parameter int               N_CH        = 8,
  parameter int               DATA_W      = 16,
  parameter int               CMD_W       = 4,
  parameter logic [CMD_W-1:0] CMD_WRITE   = CMD_W'(3),
  parameter int               REFRESH_DIV = 1000000,
  parameter int               TIMEOUT     = 1023,
  parameter int               WORD_W      = CMD_W + 4 + DATA_W
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [N_CH*DATA_W-1:0] cfg_data,
  input  logic                   load_all,
  input  logic                   sw_valid,
  input  logic [WORD_W-1:0]      sw_word,
  output logic                   sw_ready,
  output logic [WORD_W-1:0]      dac_word,
  output logic                   dac_start,
  input  logic                   dac_busy,
  output logic                   seq_active,
  output logic                   timeout_err,
  input  logic                   err_clear
);

  localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [RW-1:0] REF_LAST = RW'((REFRESH_DIV > 0) ? REFRESH_DIV - 1 : 0);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT);
  localparam logic [3:0]    IDX_LAST = 4'(N_CH - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

  state_t            state;
  logic [3:0]        index;
  logic              seq_pending;
  logic [RW-1:0]     refresh_cnt;
  logic [TW-1:0]     tmo_cnt;
  logic              prio_sw;
  logic              grant_sw;
  logic              refresh_wrap;
  logic [DATA_W-1:0] cfg_ch [16];

  // Padding unused channel slots lets the 4-bit index address the table directly.
  for (genvar g = 0; g < 16; g++) begin : g_ch
    if (g < N_CH) begin : g_used
      assign cfg_ch[g] = cfg_data[g*DATA_W +: DATA_W];
    end else begin : g_pad
      assign cfg_ch[g] = '0;
    end
  end

  assign refresh_wrap = (REFRESH_DIV > 0) && (refresh_cnt == REF_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      dac_word    <= '0;
      dac_start   <= 1'b0;
      sw_ready    <= 1'b0;
      seq_active  <= 1'b0;
      timeout_err <= 1'b0;
      seq_pending <= 1'b0;
      index       <= '0;
      refresh_cnt <= '0;
      tmo_cnt     <= '0;
      prio_sw     <= 1'b0;
      grant_sw    <= 1'b0;
    end else begin
      dac_start <= 1'b0;
      sw_ready  <= 1'b0;
      if (REFRESH_DIV > 0) refresh_cnt <= refresh_wrap ? '0 : refresh_cnt + 1'b1;

      case (state)
        IDLE: begin
          if (seq_pending && !seq_active) begin
            seq_active  <= 1'b1;
            index       <= '0;
            seq_pending <= 1'b0;
          end
          // Priority pointer flips on every grant so contention alternates.
          if (sw_valid && (!seq_active || prio_sw)) begin
            grant_sw <= 1'b1;
            prio_sw  <= ~prio_sw;
            state    <= ISSUE;
          end else if (seq_active) begin
            grant_sw <= 1'b0;
            prio_sw  <= ~prio_sw;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          dac_word  <= grant_sw ? sw_word : {CMD_WRITE, index, cfg_ch[index]};
          dac_start <= 1'b1;
          sw_ready  <= grant_sw;
          tmo_cnt   <= '0;
          state     <= WAIT_HI;
        end
        WAIT_HI: begin
          if (dac_busy) begin
            tmo_cnt <= '0;
            state   <= WAIT_LO;
          end else if (tmo_cnt == TMO_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            if (!grant_sw) begin
              seq_active <= 1'b0;
              index      <= '0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        WAIT_LO: begin
          if (!dac_busy) begin
            state <= IDLE;
            if (!grant_sw) begin
              if (index == IDX_LAST) begin
                seq_active <= 1'b0;
                index      <= '0;
              end else begin
                index <= index + 1'b1;
              end
            end
          end else if (tmo_cnt == TMO_LAST) begin
            timeout_err <= 1'b1;
            state       <= IDLE;
            if (!grant_sw) begin
              seq_active <= 1'b0;
              index      <= '0;
            end
          end else begin
            tmo_cnt <= tmo_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      // New requests outrank the clear from a sequence start so none is lost.
      if (load_all || refresh_wrap) seq_pending <= 1'b1;
      if (err_clear) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dac_update_sequencer.sv
// Directed bench: one sequencer without refresh for software/sequence/contention
// traffic, and one with a 200-clock refresh and short timeout.
module tb_dac_update_sequencer;

  localparam int N_CH   = 8;
  localparam int DATA_W = 16;
  localparam int WORD_W = 24;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [N_CH*DATA_W-1:0] cfg_data;
  logic                   reset_n, load_all, sw_valid, err_clear, dac_busy;
  logic [WORD_W-1:0]      sw_word, dac_word;
  logic                   sw_ready, dac_start, seq_active, timeout_err;
  logic                   rf_reset_n, rf_load_all, rf_sw_valid, rf_err_clear, rf_dac_busy;
  logic [WORD_W-1:0]      rf_sw_word, rf_dac_word;
  logic                   rf_sw_ready, rf_dac_start, rf_seq_active, rf_timeout_err;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;

  dac_update_sequencer #(.N_CH(N_CH), .DATA_W(DATA_W), .CMD_W(4), .CMD_WRITE(4'h3),
                         .REFRESH_DIV(0), .TIMEOUT(63)) u_dut (
    .clk(clk), .reset_n(reset_n), .cfg_data(cfg_data), .load_all(load_all),
    .sw_valid(sw_valid), .sw_word(sw_word), .sw_ready(sw_ready), .dac_word(dac_word),
    .dac_start(dac_start), .dac_busy(dac_busy), .seq_active(seq_active),
    .timeout_err(timeout_err), .err_clear(err_clear));

  dac_update_sequencer #(.N_CH(N_CH), .DATA_W(DATA_W), .CMD_W(4), .CMD_WRITE(4'h3),
                         .REFRESH_DIV(200), .TIMEOUT(15)) u_rf (
    .clk(clk), .reset_n(rf_reset_n), .cfg_data(cfg_data), .load_all(rf_load_all),
    .sw_valid(rf_sw_valid), .sw_word(rf_sw_word), .sw_ready(rf_sw_ready),
    .dac_word(rf_dac_word), .dac_start(rf_dac_start), .dac_busy(rf_dac_busy),
    .seq_active(rf_seq_active), .timeout_err(rf_timeout_err), .err_clear(rf_err_clear));

  always @(posedge clk) cyc <= cyc + 1;

  logic [WORD_W-1:0] start_words[$];
  logic              start_rdy[$];
  int                ready_cnt = 0;
  int                rf_rise[$];
  logic              rf_prev = 1'b0;

  always @(negedge clk) begin
    if (dac_start === 1'b1) begin
      start_words.push_back(dac_word);
      start_rdy.push_back(sw_ready);
    end
    if (sw_ready === 1'b1) ready_cnt <= ready_cnt + 1;
    if (rf_seq_active === 1'b1 && rf_prev === 1'b0) rf_rise.push_back(cyc);
    rf_prev <= rf_seq_active;
  end

  // Serializer models: busy rises ser_delay cycles after a start, stays up ser_len cycles.
  int ser_delay = 3, ser_len = 50, rf_delay = 2, rf_len = 4;
  bit ser_en = 1'b1, rf_ser_en = 1'b0;

  initial begin
    dac_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (ser_en && dac_start === 1'b1) begin
        repeat (ser_delay) @(negedge clk);
        dac_busy = 1'b1;
        repeat (ser_len) @(negedge clk);
        dac_busy = 1'b0;
      end
    end
  end

  initial begin
    rf_dac_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (rf_ser_en && rf_dac_start === 1'b1) begin
        repeat (rf_delay) @(negedge clk);
        rf_dac_busy = 1'b1;
        repeat (rf_len) @(negedge clk);
        rf_dac_busy = 1'b0;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic ld, input logic sv, input logic [WORD_W-1:0] sw);
    load_all = ld;
    sw_valid = sv;
    sw_word  = sw;
    @(negedge clk);
  endtask

  task automatic clearLog();
    @(posedge clk);
    #1;
    start_words.delete();
    start_rdy.delete();
    ready_cnt = 0;
    @(negedge clk);
  endtask

  task automatic runMain();
    int guard, nsw, j;
    bit p3, p5;
    logic [WORD_W-1:0] exp;
    repeat (2) @(negedge clk);
    checkOutput("rst_dac_start", dac_start, 0);
    checkOutput("rst_sw_ready", sw_ready, 0);
    checkOutput("rst_dac_word", dac_word, 0);
    checkOutput("rst_seq_active", seq_active, 0);
    checkOutput("rst_timeout_err", timeout_err, 0);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    $display("[TB] single software word");
    ser_delay = 3; ser_len = 50;
    clearLog();
    applyStimulus(1'b0, 1'b1, 24'h312345);
    checkOutput("sw_start_c1", dac_start, 0);
    applyStimulus(1'b0, 1'b1, 24'h312345);
    checkOutput("sw_start_c2", dac_start, 1);
    checkOutput("sw_ready_c2", sw_ready, 1);
    checkOutput("sw_word_c2", dac_word, 24'h312345);
    applyStimulus(1'b0, 1'b0, 24'h312345);
    checkOutput("sw_ready_once", sw_ready, 0);
    repeat (30) @(negedge clk);
    checkOutput("sw_word_held", dac_word, 24'h312345);
    repeat (40) @(negedge clk);
    checkOutput("sw_n_starts", start_words.size(), 1);
    checkOutput("sw_no_timeout", timeout_err, 0);
    applyStimulus(1'b0, 1'b1, 24'h3ABCDE);
    checkOutput("sw2_start_c1", dac_start, 0);
    applyStimulus(1'b0, 1'b1, 24'h3ABCDE);
    checkOutput("sw2_start_c2", dac_start, 1);
    checkOutput("sw2_word_c2", dac_word, 24'h3ABCDE);
    applyStimulus(1'b0, 1'b0, 24'h0);
    repeat (70) @(negedge clk);
    checkOutput("sw_ready_total", ready_cnt, 2);

    $display("[TB] load_all with two merged restart requests");
    ser_delay = 1; ser_len = 3;
    clearLog();
    applyStimulus(1'b1, 1'b0, 24'h0);
    load_all = 1'b0;
    guard = 0; p3 = 1'b0; p5 = 1'b0;
    while (!(start_words.size() >= 16 && seq_active === 1'b0) && guard < 1000) begin
      @(negedge clk);
      guard++;
      load_all = 1'b0;
      if (start_words.size() == 3 && !p3) begin load_all = 1'b1; p3 = 1'b1; end
      if (start_words.size() == 5 && !p5) begin load_all = 1'b1; p5 = 1'b1; end
    end
    load_all = 1'b0;
    checkOutput("seq_done_in_time", guard < 1000, 1);
    repeat (40) @(negedge clk);
    checkOutput("seq_n_starts", start_words.size(), 16);
    for (int i = 0; i < 16; i++) begin
      j = i % 8;
      exp = {4'h3, 4'(j), 16'h1000 + 16'(j)};
      checkOutput($sformatf("seq_word_%0d", i), start_words[i], exp);
    end
    checkOutput("seq_no_ready", ready_cnt, 0);
    checkOutput("seq_inactive", seq_active, 0);

    $display("[TB] contention between software and sequencer");
    reset_n = 1'b0;
    @(negedge clk);
    checkOutput("rst2_dac_word", dac_word, 0);
    reset_n = 1'b1;
    @(negedge clk);
    clearLog();
    applyStimulus(1'b1, 1'b0, 24'h0);
    load_all = 1'b0;
    guard = 0;
    while (seq_active !== 1'b1 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("cont_seq_started", seq_active, 1);
    sw_word  = 24'h5A0000;
    sw_valid = 1'b1;
    nsw = 0; guard = 0;
    while ((sw_valid || seq_active) && guard < 2000) begin
      @(negedge clk);
      guard++;
      if (sw_ready === 1'b1) begin
        nsw++;
        sw_word = 24'h5A0000 | WORD_W'(nsw);
        if (nsw == 8) sw_valid = 1'b0;
      end
    end
    sw_valid = 1'b0;
    checkOutput("cont_done_in_time", guard < 2000, 1);
    repeat (20) @(negedge clk);
    checkOutput("cont_n_starts", start_words.size(), 16);
    for (int i = 0; i < 16; i++) begin
      j = i / 2;
      exp = (i % 2 == 0) ? {4'h3, 4'(j), 16'h1000 + 16'(j)} : (24'h5A0000 | 24'(j));
      checkOutput($sformatf("cont_word_%0d", i), start_words[i], exp);
      checkOutput($sformatf("cont_ready_%0d", i), start_rdy[i], i % 2);
    end
    checkOutput("cont_ready_total", ready_cnt, 8);
  endtask

  task automatic runRefresh();
    int guard, d1, d2;
    repeat (2) @(negedge clk);
    checkOutput("rf_rst_seq_active", rf_seq_active, 0);
    rf_reset_n = 1'b1;

    // Refresh wraps on clock 200, sequence starts on 201, grant 202, ISSUE 203.
    guard = 0;
    do begin @(negedge clk); guard++; end while (rf_dac_start !== 1'b1 && guard < 400);
    checkOutput("rf_first_start_cycle", guard, 203);
    checkOutput("rf_first_word", rf_dac_word, 24'h301000);
    for (int k = 1; k <= 16; k++) begin
      @(negedge clk);
      checkOutput($sformatf("rf_tmo_err_%0d", k), rf_timeout_err, k == 16);
      checkOutput($sformatf("rf_tmo_active_%0d", k), rf_seq_active, k < 16);
    end
    rf_err_clear = 1'b1;
    @(negedge clk);
    rf_err_clear = 1'b0;
    checkOutput("rf_err_clear", rf_timeout_err, 0);

    guard = 0;
    do begin @(negedge clk); guard++; end while (rf_dac_start !== 1'b1 && guard < 400);
    checkOutput("rf_second_start_seen", rf_dac_start, 1);
    repeat (15) @(negedge clk);
    rf_err_clear = 1'b1;
    @(negedge clk);
    checkOutput("rf_clear_beats_timeout", rf_timeout_err, 0);
    rf_err_clear = 1'b0;
    @(negedge clk);
    checkOutput("rf_clear_stays", rf_timeout_err, 0);

    $display("[TB] periodic refresh with serializer responding");
    rf_ser_en = 1'b1;
    guard = 0;
    while (rf_dac_busy !== 1'b1 && guard < 400) begin
      @(negedge clk);
      guard++;
    end
    checkOutput("rf_busy_seen", rf_dac_busy, 1);
    if (rf_rise.size() >= 3) begin
      d1 = rf_rise[1] - rf_rise[0];
      d2 = rf_rise[2] - rf_rise[1];
    end else begin
      d1 = -1;
      d2 = -1;
    end
    checkOutput("rf_period_1", d1, 200);
    checkOutput("rf_period_2", d2, 200);

    @(posedge clk);
    #2;
    rf_reset_n = 1'b0;
    #1;
    checkOutput("rf_rst_dac_start", rf_dac_start, 0);
    checkOutput("rf_rst_sw_ready", rf_sw_ready, 0);
    checkOutput("rf_rst_dac_word", rf_dac_word, 0);
    checkOutput("rf_rst_active", rf_seq_active, 0);
    checkOutput("rf_rst_err", rf_timeout_err, 0);
    repeat (3) @(negedge clk);
    rf_reset_n = 1'b1;
    guard = 0;
    do begin @(negedge clk); guard++; end while (rf_dac_start !== 1'b1 && guard < 400);
    checkOutput("rf_restart_cycle", guard, 203);
    checkOutput("rf_restart_word", rf_dac_word, 24'h301000);
  endtask

  initial begin
    cfg_data = '0;
    for (int k = 0; k < N_CH; k++) cfg_data[k*DATA_W +: DATA_W] = 16'h1000 + 16'(k);
    load_all = 1'b0; sw_valid = 1'b0; sw_word = '0; err_clear = 1'b0;
    rf_load_all = 1'b0; rf_sw_valid = 1'b0; rf_sw_word = '0; rf_err_clear = 1'b0;
    reset_n = 1'b1;
    rf_reset_n = 1'b1;
    #2;
    reset_n = 1'b0;
    rf_reset_n = 1'b0;
    fork
      runMain();
      runRefresh();
    join
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
